branch_resolve_bht: RTL

//  EX-stage branch resolver and dynamic predictor, directly downstream of the ALU.
//  - Consumes the ALU result for a branch and decides the actual direction.
//  - Compares that direction with the fetch-time prediction and raises a registered mispredict/redirect.
//  - Owns the 2-bit saturating-counter BHT, which IF reads combinationally for next-fetch prediction.

---
 rtl/branch_resolve_bht.sv | 138 +++++++++++++
 1 files changed

// File: rtl/branch_resolve_bht.sv
// branch_resolve_bht
//   EX-stage branch resolver with a 2-bit saturating-counter branch history
//   table (BHT). It resolves the actual direction of the branch in EX from the
//   ALU result, compares it with the prediction carried down from IF, and
//   produces a registered mispredict/redirect. IF reads the BHT
//   combinationally.
//
// Ports
//   clk            core clock, rising edge
//   rst_n          asynchronous active-low reset
//   if_pc          fetch PC used for the BHT lookup
//   if_pred_taken  MSB of the indexed counter (combinational, pre-update value)
//   ex_valid       EX holds a valid branch
//   ex_br_type     00 BEQ, 01 BNE, 10 BLT, 11 BGE
//   ex_alu_out     ALU result (equality flag in bit 0, or A-B)
//   ex_pc          PC of the branch in EX
//   ex_target      computed taken target
//   ex_pred_taken  prediction made at fetch
//   mispredict     registered one-cycle flush pulse
//   redirect_pc    registered correct next PC, valid while mispredict=1
//   br_resolved    registered pulse, one branch retired from EX
//   stat_branches  (BP_STATS_EN only) count of resolved branches
//   stat_mispred   (BP_STATS_EN only) count of mispredicts
//
// Configuration
//   BP_STATS_EN    when defined, adds the two 32-bit statistics counters.

module branch_resolve_bht #(
    parameter int         IDX_W   = 6,
    parameter int         XLEN    = 32,
    parameter logic [1:0] CNT_RST = 2'b01
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    input  logic            ex_valid,
    input  logic [1:0]      ex_br_type,
    input  logic [XLEN-1:0] ex_alu_out,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
`ifdef BP_STATS_EN
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispred,
`endif
    output logic            br_resolved
);

    localparam int ENTRIES = 1 << IDX_W;

    localparam logic [1:0] BR_BEQ = 2'b00;
    localparam logic [1:0] BR_BNE = 2'b01;
    localparam logic [1:0] BR_BLT = 2'b10;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    logic [1:0]             bht [ENTRIES];
    logic [IDX_W-1:0]       if_idx;
    logic [IDX_W-1:0]       ex_idx_p0;
    logic signed [XLEN-1:0] alu_s_p0;
    logic                   vld_p0;
    logic                   taken_p0;
    logic [XLEN-1:0]        seq_pc_p0;
    logic                   unused_pc_bits;

    assign if_idx         = if_pc[IDX_W+1:2];
    assign if_pred_taken  = bht[if_idx][1];
    assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

    // Stage p0: resolve the branch in EX. The instruction sitting in EX while
    // a mispredict pulse is out is wrong-path and must be dropped.
    assign vld_p0    = ex_valid & ~mispredict;
    assign ex_idx_p0 = ex_pc[IDX_W+1:2];
    assign alu_s_p0  = ex_alu_out;
    assign seq_pc_p0 = ex_pc + XLEN'(4);

    always_comb begin
        taken_p0 = 1'b0;
        case (ex_br_type)
            BR_BEQ:  taken_p0 = ex_alu_out[0];
            BR_BNE:  taken_p0 = ~ex_alu_out[0];
            BR_BLT:  taken_p0 = (alu_s_p0 < 0);
            default: taken_p0 = ~(alu_s_p0 < 0);
        endcase
    end

    // Stage p1: registered resolution outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict  <= 1'b0;
            br_resolved <= 1'b0;
            redirect_pc <= '0;
        end else begin
            br_resolved <= vld_p0;
            mispredict  <= vld_p0 & (taken_p0 != ex_pred_taken);
            if (vld_p0) begin
                redirect_pc <= taken_p0 ? ex_target : seq_pc_p0;
            end
        end
    end

    // Counter update lands on the same edge; IF sees it one cycle later
    // because the read path has no write bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht[i] <= CNT_RST;
            end
        end else if (vld_p0) begin
            bht[ex_idx_p0] <= taken_p0 ? sat_inc(bht[ex_idx_p0]) : sat_dec(bht[ex_idx_p0]);
        end
    end

`ifdef BP_STATS_EN
    // Counted on the edge that raises the corresponding pulse; wraps freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else if (vld_p0) begin
            stat_branches <= stat_branches + 32'd1;
            if (taken_p0 != ex_pred_taken) begin
                stat_mispred <= stat_mispred + 32'd1;
            end
        end
    end
`endif

endmodule
